// File: rtl/agex_stage_pkg.sv
// Shared definitions for the LC-3b AGEX stage: control-store bit map,
// field encodings and the MEM pipeline latch layout.
package agex_stage_pkg;

    localparam int DATA_W    = 16;
    localparam int AGEX_CS_W = 20;
    localparam int MEM_CS_W  = 11;

    // agex_cs bit positions
    localparam int CS_ADDR1MUX    = 19;
    localparam int CS_ADDR2MUX_HI = 18;
    localparam int CS_ADDR2MUX_LO = 17;
    localparam int CS_LSHF1       = 16;
    localparam int CS_ADDRESSMUX  = 15;
    localparam int CS_SR2MUX      = 14;
    localparam int CS_ALUK_HI     = 13;
    localparam int CS_ALUK_LO     = 12;
    localparam int CS_RESULTMUX   = 11;
    localparam int CS_BR_OP       = 10;
    localparam int CS_UNCOND_OP   = 9;
    localparam int CS_TRAP_OP     = 8;
    localparam int CS_BR_STALL    = 7;
    localparam int CS_DCACHE_EN   = 6;
    localparam int CS_DCACHE_RW   = 5;
    localparam int CS_DATA_SIZE   = 4;
    localparam int CS_DRVMUX_HI   = 3;
    localparam int CS_DRVMUX_LO   = 2;
    localparam int CS_LD_REG      = 1;
    localparam int CS_LD_CC       = 0;

    typedef enum logic [1:0] {
        ALUK_ADD   = 2'b00,
        ALUK_AND   = 2'b01,
        ALUK_XOR   = 2'b10,
        ALUK_PASSB = 2'b11
    } aluk_e;

    typedef enum logic [1:0] {
        ADDR2_ZERO  = 2'b00,
        ADDR2_OFF6  = 2'b01,
        ADDR2_OFF9  = 2'b10,
        ADDR2_OFF11 = 2'b11
    } addr2mux_e;

    typedef enum logic [1:0] {
        SHF_LSHF   = 2'b00,
        SHF_RSHFL0 = 2'b01,
        SHF_RSHFL1 = 2'b10,
        SHF_RSHFA  = 2'b11
    } shf_e;

    typedef struct packed {
        logic [DATA_W-1:0]   npc;
        logic [DATA_W-1:0]   ir;
        logic [DATA_W-1:0]   address;
        logic [DATA_W-1:0]   alu_result;
        logic [MEM_CS_W-1:0] cs;
        logic [2:0]          cc;
        logic [2:0]          drid;
        logic                v;
    } mem_latch_t;

endpackage

// File: rtl/agex_stage_if.sv
// AGEX input latches (from decode) and MEM output latches bundled as one bus.
interface agex_stage_if;
    import agex_stage_pkg::*;

    logic [DATA_W-1:0]    agex_npc;
    logic [DATA_W-1:0]    agex_ir;
    logic [AGEX_CS_W-1:0] agex_cs;
    logic [DATA_W-1:0]    agex_sr1;
    logic [DATA_W-1:0]    agex_sr2;
    logic [2:0]           agex_cc;
    logic [2:0]           agex_drid;
    logic                 agex_v;

    logic [DATA_W-1:0]    mem_npc;
    logic [DATA_W-1:0]    mem_ir;
    logic [DATA_W-1:0]    mem_address;
    logic [DATA_W-1:0]    mem_alu_result;
    logic [MEM_CS_W-1:0]  mem_cs;
    logic [2:0]           mem_cc;
    logic [2:0]           mem_drid;
    logic                 mem_v;

    // Upstream side: supplies AGEX latches, observes MEM latches
    modport master (
        output agex_npc, agex_ir, agex_cs, agex_sr1, agex_sr2, agex_cc, agex_drid, agex_v,
        input  mem_npc, mem_ir, mem_address, mem_alu_result, mem_cs, mem_cc, mem_drid, mem_v
    );

    // Stage side
    modport slave (
        input  agex_npc, agex_ir, agex_cs, agex_sr1, agex_sr2, agex_cc, agex_drid, agex_v,
        output mem_npc, mem_ir, mem_address, mem_alu_result, mem_cs, mem_cc, mem_drid, mem_v
    );
endinterface

// File: rtl/agex_stage_alu.sv
// Combinational ALU, barrel shifter and result select for the AGEX stage.
module agex_alu
    import agex_stage_pkg::*;
(
    input  logic [DATA_W-1:0] sr1_i,
    input  logic [DATA_W-1:0] sr2_i,
    input  logic [5:0]        ir_i,
    input  logic              sr2mux_i,
    input  aluk_e             aluk_i,
    input  logic              resultmux_i,
    output logic [DATA_W-1:0] result_o
);

    logic [DATA_W-1:0]        b_opnd;
    logic [DATA_W-1:0]        alu_out;
    logic [DATA_W-1:0]        shf_out;
    logic signed [DATA_W-1:0] sr1_s;

    assign sr1_s = $signed(sr1_i);

    // ALU: second operand is either the 5-bit immediate or SR2
    always_comb begin
        b_opnd = sr2mux_i ? {{(DATA_W-5){ir_i[4]}}, ir_i[4:0]} : sr2_i;
        alu_out = '0;
        case (aluk_i)
            ALUK_ADD:   alu_out = sr1_i + b_opnd;
            ALUK_AND:   alu_out = sr1_i & b_opnd;
            ALUK_XOR:   alu_out = sr1_i ^ b_opnd;
            ALUK_PASSB: alu_out = b_opnd;
            default:    alu_out = '0;
        endcase
    end

    // Shifter: IR[5:4] picks the shift kind, both 01 and 10 are logical right
    always_comb begin
        shf_out = '0;
        case (shf_e'(ir_i[5:4]))
            SHF_LSHF:   shf_out = sr1_i << ir_i[3:0];
            SHF_RSHFL0: shf_out = sr1_i >> ir_i[3:0];
            SHF_RSHFL1: shf_out = sr1_i >> ir_i[3:0];
            SHF_RSHFA:  shf_out = $unsigned(sr1_s >>> ir_i[3:0]);
            default:    shf_out = '0;
        endcase
    end

    assign result_o = resultmux_i ? alu_out : shf_out;

endmodule

// File: rtl/agex_stage.sv
// LC-3b AGEX stage: address generation, ALU/shift execute and the MEM latches.
module agex_stage
    import agex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_stall,
    input  logic         v_mem_br_stall,
    agex_stage_if.slave  bus,
    output logic         v_agex_ld_reg,
    output logic         v_agex_ld_cc,
    output logic         v_agex_br_stall
);

    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] addr2;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] ir;
    mem_latch_t        mem_d;
    mem_latch_t        mem_q;

    assign ir = bus.agex_ir;

    // Dependency/stall signals back to fetch and decode
    assign v_agex_ld_reg   = bus.agex_v & bus.agex_cs[CS_LD_REG];
    assign v_agex_ld_cc    = bus.agex_v & bus.agex_cs[CS_LD_CC];
    assign v_agex_br_stall = bus.agex_v & bus.agex_cs[CS_BR_STALL];

    // Address adder: base select, offset select with optional word scaling
    always_comb begin
        addr1 = bus.agex_cs[CS_ADDR1MUX] ? bus.agex_sr1 : bus.agex_npc;
        addr2 = '0;
        case (addr2mux_e'(bus.agex_cs[CS_ADDR2MUX_HI:CS_ADDR2MUX_LO]))
            ADDR2_ZERO:  addr2 = '0;
            ADDR2_OFF6:  addr2 = {{(DATA_W-6){ir[5]}}, ir[5:0]};
            ADDR2_OFF9:  addr2 = {{(DATA_W-9){ir[8]}}, ir[8:0]};
            ADDR2_OFF11: addr2 = {{(DATA_W-11){ir[10]}}, ir[10:0]};
            default:     addr2 = '0;
        endcase
        if (bus.agex_cs[CS_LSHF1]) begin
            addr2 = addr2 << 1;
        end
        // Trap vector path: zero-extended 8-bit vector scaled to a word address
        address = bus.agex_cs[CS_ADDRESSMUX] ? (addr1 + addr2)
                                             : {{(DATA_W-9){1'b0}}, ir[7:0], 1'b0};
    end

    agex_alu u_alu (
        .sr1_i       (bus.agex_sr1),
        .sr2_i       (bus.agex_sr2),
        .ir_i        (ir[5:0]),
        .sr2mux_i    (bus.agex_cs[CS_SR2MUX]),
        .aluk_i      (aluk_e'(bus.agex_cs[CS_ALUK_HI:CS_ALUK_LO])),
        .resultmux_i (bus.agex_cs[CS_RESULTMUX]),
        .result_o    (alu_result)
    );

    // Next MEM latch contents: hold on a dcache stall, else load and squash V on a MEM branch
    always_comb begin
        mem_d = mem_q;
        if (!mem_stall) begin
            mem_d.npc        = bus.agex_npc;
            mem_d.ir         = bus.agex_ir;
            mem_d.address    = address;
            mem_d.alu_result = alu_result;
            mem_d.cs         = bus.agex_cs[MEM_CS_W-1:0];
            mem_d.cc         = bus.agex_cc;
            mem_d.drid       = bus.agex_drid;
            mem_d.v          = bus.agex_v & ~v_mem_br_stall;
        end
    end

    // MEM pipeline latches, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.mem_npc        = mem_q.npc;
    assign bus.mem_ir         = mem_q.ir;
    assign bus.mem_address    = mem_q.address;
    assign bus.mem_alu_result = mem_q.alu_result;
    assign bus.mem_cs         = mem_q.cs;
    assign bus.mem_cc         = mem_q.cc;
    assign bus.mem_drid       = mem_q.drid;
    assign bus.mem_v          = mem_q.v;

endmodule
